// File: rtl/peripheral_bus_pkg.sv
// Shared definitions for the peripheral bus: base addresses, register offsets,
// TCON bit positions, bus request payload and the peripheral offset decoder.
package peripheral_bus_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned TCON_W   = 3;
    localparam int unsigned LEDS_W   = 8;
    localparam int unsigned DIGITS_W = 12;

    localparam logic [31:0] RAM_BASE_DEFAULT    = 32'h0000_0000;
    localparam logic [31:0] PERIPH_BASE_DEFAULT = 32'h4000_0000;

    localparam logic [31:0] OFF_TH      = 32'h0000_0000;
    localparam logic [31:0] OFF_TL      = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
    localparam logic [31:0] OFF_LEDS    = 32'h0000_000C;
    localparam logic [31:0] OFF_DIGITS  = 32'h0000_0010;
    localparam logic [31:0] OFF_SYSTICK = 32'h0000_0014;

    localparam int unsigned TCON_EN = 0;
    localparam int unsigned TCON_IE = 1;
    localparam int unsigned TCON_IS = 2;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LEDS,
        SEL_DIGITS,
        SEL_SYSTICK
    } bus_sel_e;

    // Map a word-aligned offset from PERIPH_BASE to a register select.
    function automatic bus_sel_e periph_sel(input logic [31:0] off);
        bus_sel_e sel;
        case (off)
            OFF_TH:      sel = SEL_TH;
            OFF_TL:      sel = SEL_TL;
            OFF_TCON:    sel = SEL_TCON;
            OFF_LEDS:    sel = SEL_LEDS;
            OFF_DIGITS:  sel = SEL_DIGITS;
            OFF_SYSTICK: sel = SEL_SYSTICK;
            default:     sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/peripheral_bus_timer.sv
// Reload timer: TH reload value, TL up-counter, TCON control/status, level irq.
module bus_timer
    import peripheral_bus_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_th,
    input  logic              wr_tl,
    input  logic              wr_tcon,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] th,
    output logic [DATA_W-1:0] tl,
    output logic [TCON_W-1:0] tcon,
    output logic              irq
);

    logic wrap;

    assign wrap = tcon[TCON_EN] && (tl == '1);

    // Bus writes take priority over the timer for the register they target.
    always_ff @(posedge clk) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wr_th) begin
                th <= wdata;
            end
            if (wr_tl) begin
                tl <= wdata;
            end else if (tcon[TCON_EN]) begin
                tl <= wrap ? th : tl + DATA_W'(1);
            end
            if (wr_tcon) begin
                tcon <= wdata[TCON_W-1:0];
            end else if (wrap) begin
                tcon[TCON_IS] <= tcon[TCON_IE] | tcon[TCON_IS];
            end
        end
    end

    assign irq = tcon[TCON_IE] & tcon[TCON_IS];

endmodule

// File: rtl/peripheral_bus.sv
// Memory-stage bus: decodes CPU accesses to data RAM and memory-mapped
// peripherals (timer, LEDs, 7-segment digits, free-running SYSTICK).
module peripheral_bus
    import peripheral_bus_pkg::*;
#(
    parameter int unsigned RAM_WORDS   = 512,
    parameter logic [31:0] RAM_BASE    = RAM_BASE_DEFAULT,
    parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] MemBus_Address,
    input  logic [31:0] MemBus_Write_Data,
    output logic [31:0] Device_Read_Data,
    output logic        irq,
    output logic [7:0]  leds,
    output logic [11:0] digits
);

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

    bus_req_t          req;
    logic [31:0]       word_addr;
    logic [32:0]       ram_diff;
    logic [32:0]       per_diff;
    logic              ram_hit;
    logic [RAM_AW-1:0] ram_idx;
    bus_sel_e          sel;

    logic [DATA_W-1:0] mem [RAM_WORDS];
    logic [DATA_W-1:0] th;
    logic [DATA_W-1:0] tl;
    logic [TCON_W-1:0] tcon;
    logic [DATA_W-1:0] systick;

    assign req = '{rd: MemRead, wr: MemWrite, addr: MemBus_Address, wdata: MemBus_Write_Data};

    // Byte-lane bits are don't-care; bit 32 of each difference is the borrow (below base).
    assign word_addr = req.addr & ~32'h3;
    assign ram_diff  = 33'(word_addr) - 33'(RAM_BASE);
    assign per_diff  = 33'(word_addr) - 33'(PERIPH_BASE);
    assign ram_hit   = !ram_diff[32] && ((ram_diff[31:0] >> 2) < RAM_WORDS);
    assign ram_idx   = ram_diff[RAM_AW+1:2];

    always_comb begin
        sel = SEL_NONE;
        if (ram_hit) begin
            sel = SEL_RAM;
        end else if (!per_diff[32]) begin
            sel = periph_sel(per_diff[31:0]);
        end
    end

    // Data RAM: sync write, async read; contents survive reset.
    always_ff @(posedge clk) begin
        if (req.wr && !reset && (sel == SEL_RAM)) begin
            mem[ram_idx] <= req.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds    <= '0;
            digits  <= '0;
            systick <= '0;
        end else begin
            systick <= systick + DATA_W'(1);
            if (req.wr && (sel == SEL_LEDS)) begin
                leds <= req.wdata[LEDS_W-1:0];
            end
            if (req.wr && (sel == SEL_DIGITS)) begin
                digits <= req.wdata[DIGITS_W-1:0];
            end
        end
    end

    bus_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_th   (req.wr && (sel == SEL_TH)),
        .wr_tl   (req.wr && (sel == SEL_TL)),
        .wr_tcon (req.wr && (sel == SEL_TCON)),
        .wdata   (req.wdata),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irq     (irq)
    );

    // Zero-wait read mux; reflects register state before this cycle's write.
    always_comb begin
        Device_Read_Data = '0;
        if (req.rd) begin
            case (sel)
                SEL_RAM:     Device_Read_Data = mem[ram_idx];
                SEL_TH:      Device_Read_Data = th;
                SEL_TL:      Device_Read_Data = tl;
                SEL_TCON:    Device_Read_Data = {29'b0, tcon};
                SEL_LEDS:    Device_Read_Data = {24'b0, leds};
                SEL_DIGITS:  Device_Read_Data = {20'b0, digits};
                SEL_SYSTICK: Device_Read_Data = systick;
                default:     Device_Read_Data = '0;
            endcase
        end
    end

endmodule

// File: doc/peripheral_bus.md
PERIPHERAL_BUS -- requirements
Module: peripheral_bus

Interface
REQ-001 Param RAM_WORDS, default 512, data-RAM depth in 32-bit words (power of two).
REQ-002 Param RAM_BASE, default 32'h0000_0000, data-RAM byte base address.
REQ-003 Param PERIPH_BASE, default 32'h4000_0000, peripheral register block byte base address.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-006 MemRead  input  1  CPU read strobe, MEM stage.
REQ-007 MemWrite  input  1  CPU write strobe, MEM stage.
REQ-008 MemBus_Address  input  32  byte address; bits [1:0] ignored (word access only).
REQ-009 MemBus_Write_Data  input  32  write data.
REQ-010 Device_Read_Data  output  32  read data returned to CPU.
REQ-011 irq  output  1  timer interrupt request, level.
REQ-012 leds  output  8  LED register contents.
REQ-013 digits  output  12  display register {an[3:0], seg[7:0]}.

Function
REQ-014 Decode: RAM hit when RAM_BASE <= addr < RAM_BASE+4*RAM_WORDS; peripheral offsets from PERIPH_BASE: 0x00 TH, 0x04 TL, 0x08 TCON, 0x0C LEDS, 0x10 DIGITS, 0x14 SYSTICK; all else unmapped.
REQ-015 Read path combinational: Device_Read_Data valid same cycle MemRead=1, zero-wait; MEM_WB latches it at next edge.
REQ-016 Device_Read_Data SHALL be 0 when MemRead=0 or address unmapped.
REQ-017 Reads of TCON return {29'b0, TCON[2:0]}; LEDS return {24'b0, leds}; DIGITS return {20'b0, digits}.
REQ-018 Writes commit at clk rising edge when MemWrite=1; unmapped and SYSTICK writes ignored, no side effect.
REQ-019 MemRead and MemWrite both high: write commits at edge; read returns pre-write value that cycle.
REQ-020 Same-cycle read of a RAM word written in prior cycle returns new value (no extra latency).
REQ-021 TCON bits: [0] enable, [1] interrupt enable, [2] interrupt status; bits [31:3] write-ignored.
REQ-022 Timer, each cycle with TCON[0]=1: TL==32'hFFFF_FFFF -> TL<=TH and TCON[2]<=TCON[1]|TCON[2]; else TL<=TL+1.
REQ-023 TCON[0]=0: TL holds; TCON[2] holds.
REQ-024 Bus write to TL or TCON in same cycle as timer update: bus write wins for written register; other timer effects still apply.
REQ-025 TCON[2] sticky; cleared only by bus write of 0 to bit 2 or reset.
REQ-026 irq = TCON[1] & TCON[2], combinational from registers.
REQ-027 SYSTICK: 32-bit free-running count, +1 every cycle, wraps 32'hFFFF_FFFF -> 0, read-only.
REQ-028 leds and digits driven directly from registers, updating the cycle after the write edge.

Reset
REQ-029 On reset: TH=0, TL=0, TCON=0, leds=0, digits=0, SYSTICK=0, irq=0.
REQ-030 Reset overrides any concurrent bus write or timer tick; RAM contents not cleared.
REQ-031 Reset mid-count: timer stops (TCON[0]=0) and restarts only after software re-enables.

Structure
REQ-032 Shared package holds address offsets (TH..SYSTICK), TCON bit indices, and RAM_BASE/PERIPH_BASE defaults.
REQ-033 One sub-module, bus_timer: owns TH/TL/TCON and irq; top owns decode, RAM, leds, digits, SYSTICK.
REQ-034 RAM inferred as single-port array, async read, sync write.

Verification
REQ-035 Write 0x1234_5678 to RAM 0x0000_0010; next cycle MemRead same address -> Device_Read_Data=0x1234_5678.
REQ-036 TH=0xFFFF_FFFC, TL=0xFFFF_FFFE, TCON=3 -> TL=0xFFFF_FFFF after 1 cycle, reloads 0xFFFF_FFFC after 2; TCON[2]=1, irq=1; write TCON=3 -> irq=0 next cycle.
REQ-037 Write LEDS 0xA5, DIGITS 0x3F1; read back 0x0000_00A5, 0x0000_03F1; outputs match.
REQ-038 Read 0x4000_0020 and read with MemRead=0 -> Device_Read_Data=0; write to SYSTICK -> count unaffected.
REQ-039 TCON=1 counting, assert reset 1 cycle -> all registers 0, irq=0, TL static afterward.
REQ-040 TL write 0x0000_0100 same edge timer would increment -> TL=0x0000_0100, then 0x0000_0101 next cycle.
